hdr_merge: RTL



---
 rtl/hdr_pkg.sv | 31 +++
 rtl/hdr_div.sv | 84 ++++++++
 rtl/hdr_merge.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hdr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hdr_pkg
//  Description : Shared widths and FSM state encoding for the HDR exposure
//                merge datapath (weighted average of three exposures).
//  Revision    : 1.0 - initial release
// ============================================================================
package hdr_pkg;

    // Base widths
    localparam int N      = 5;    // pixel width per exposure
    localparam int WW     = 12;   // weight width
    localparam int FRAC   = 4;    // fractional bits kept in the result

    // Derived widths
    localparam int PROD_W = N + WW;          // one w*p product
    localparam int ACC_W  = PROD_W + 2;      // sum of three products
    localparam int NUM_W  = ACC_W + FRAC;    // numerator, pre-scaled by 2^FRAC
    localparam int DEN_W  = WW + 2;          // sum of three weights
    localparam int Q_W    = N + FRAC;        // quotient / merged pixel width

    // Handshake FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : hdr_pkg
`default_nettype wire

// File: rtl/hdr_div.sv
`default_nettype none
// ============================================================================
//  Module      : hdr_div
//  Description : Sequential unsigned restoring divider, one quotient bit per
//                clock, MSB first. The caller guarantees the quotient fits in
//                Q_W bits, so the upper dividend bits (above Q_W) are already
//                a valid partial remainder and are preloaded on start.
//  Revision    : 1.0 - initial release
// ============================================================================
module hdr_div
    import hdr_pkg::*;
#(
    parameter int DVD_W = NUM_W,
    parameter int DVS_W = DEN_W,
    parameter int Q_W_P = Q_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [DVD_W-1:0]   i_dividend,
    input  logic [DVS_W-1:0]   i_divisor,
    output logic               o_busy,
    output logic               o_done,      // high during the final step
    output logic [Q_W_P-1:0]   o_quotient   // final quotient, valid with o_done
);

    localparam int CNT_W = (Q_W_P > 1) ? $clog2(Q_W_P) : 1;

    logic [DVS_W-1:0] r_rem;
    logic [Q_W_P-1:0] r_dvd_lo;   // dividend bits still to be shifted in
    logic [DVS_W-1:0] r_den;
    logic [Q_W_P-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic [DVS_W:0]   w_trial;
    logic             w_ge;
    logic [DVS_W-1:0] w_rem_nxt;
    logic [Q_W_P-1:0] w_q_nxt;

    // Trial subtraction: the partial remainder is always below the divisor,
    // so the difference lies within +/- divisor and its MSB is the sign.
    always_comb begin
        w_trial   = {r_rem, r_dvd_lo[Q_W_P-1]} - {1'b0, r_den};
        w_ge      = ~w_trial[DVS_W];
        w_rem_nxt = w_ge ? w_trial[DVS_W-1:0]
                         : {r_rem[DVS_W-2:0], r_dvd_lo[Q_W_P-1]};
        w_q_nxt   = {r_q[Q_W_P-2:0], w_ge};
    end

    assign o_busy     = r_busy;
    assign o_done     = r_busy && (r_cnt == '0);
    assign o_quotient = w_q_nxt;

    // Load operands on start, then iterate one quotient bit per clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem    <= '0;
            r_dvd_lo <= '0;
            r_den    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_rem    <= DVS_W'(i_dividend >> Q_W_P);
            r_dvd_lo <= i_dividend[Q_W_P-1:0];
            r_den    <= i_divisor;
            r_q      <= '0;
            r_cnt    <= CNT_W'(Q_W_P - 1);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_rem    <= w_rem_nxt;
            r_dvd_lo <= {r_dvd_lo[Q_W_P-2:0], 1'b0};
            r_q      <= w_q_nxt;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt  <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule : hdr_div
`default_nettype wire

// File: rtl/hdr_merge.sv
`default_nettype none
// ============================================================================
//  Module      : hdr_merge
//  Description : Merges three aligned exposures into one N.FRAC pixel as the
//                weight-normalised average sum(w*p)/sum(w). Falls back to the
//                mid exposure when all weights are zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module hdr_merge
    import hdr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      pixel_high,
    input  logic [N-1:0]      pixel_mid,
    input  logic [N-1:0]      pixel_low,
    input  logic [WW-1:0]     w_high,
    input  logic [WW-1:0]     w_mid,
    input  logic [WW-1:0]     w_low,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N+FRAC-1:0] pixel_out,
    output logic              div_zero
);

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [Q_W-1:0]   r_pixel_out;
    logic             r_div_zero;

    logic [N-1:0]     r_ph, r_pm, r_pl;
    logic [WW-1:0]    r_wh, r_wm, r_wl;

    logic [PROD_W-1:0] w_prod_h, w_prod_m, w_prod_l;
    logic [ACC_W-1:0]  w_acc;
    logic [NUM_W-1:0]  w_num;
    logic [DEN_W-1:0]  w_den;

    logic              w_div_start;
    logic              w_div_busy;
    logic              w_div_done;
    logic [Q_W-1:0]    w_quot;

    // Multiply-accumulate over the captured triple; NUM is pre-scaled so the
    // integer quotient carries FRAC fractional bits.
    always_comb begin
        w_prod_h = PROD_W'(r_ph) * PROD_W'(r_wh);
        w_prod_m = PROD_W'(r_pm) * PROD_W'(r_wm);
        w_prod_l = PROD_W'(r_pl) * PROD_W'(r_wl);
        w_acc    = ACC_W'(w_prod_h) + ACC_W'(w_prod_m) + ACC_W'(w_prod_l);
        w_num    = {w_acc, {FRAC{1'b0}}};
        w_den    = DEN_W'(r_wh) + DEN_W'(r_wm) + DEN_W'(r_wl);
    end

    assign w_div_start = (r_state == SUM) && (w_den != '0);

    hdr_div #(
        .DVD_W (NUM_W),
        .DVS_W (DEN_W),
        .Q_W_P (Q_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_num),
        .i_divisor  (w_den),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign pixel_out = r_pixel_out;
    assign div_zero  = r_div_zero;

    // Handshake FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_pixel_out <= '0;
            r_div_zero  <= 1'b0;
            r_ph        <= '0;
            r_pm        <= '0;
            r_pl        <= '0;
            r_wh        <= '0;
            r_wm        <= '0;
            r_wl        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_ph       <= pixel_high;
                        r_pm       <= pixel_mid;
                        r_pl       <= pixel_low;
                        r_wh       <= w_high;
                        r_wm       <= w_mid;
                        r_wl       <= w_low;
                        r_in_ready <= 1'b0;
                        r_state    <= SUM;
                    end
                end
                SUM: begin
                    if (w_den == '0) begin
                        // No usable weight: pass the mid exposure through
                        r_pixel_out <= {r_pm, {FRAC{1'b0}}};
                        r_div_zero  <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_div_zero  <= 1'b0;
                        r_state     <= DIV;
                    end
                end
                DIV: begin
                    if (w_div_done) begin
                        r_pixel_out <= w_quot;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (!w_div_busy) begin
                        // Divider idle without finishing: recover to IDLE
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule : hdr_merge
`default_nettype wire
